sha256_padder: RTL



---
 rtl/sha256_padder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sha256_padder.sv
// sha256_padder: byte-stream to padded 512-bit SHA-256 blocks with first/last
// flags. One block buffer; bytes stall while a block waits for the core.
module sha256_padder (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  input  logic         byte_last,
  output logic         byte_ready,
  input  logic         empty_msg,
  output logic         block_valid,
  output logic [511:0] block_data,
  output logic         block_first,
  output logic         block_last,
  input  logic         block_ready,
  output logic         busy
);

  localparam int unsigned BlkW = 512;
  localparam int unsigned CntW = 61;
  localparam int unsigned LenW = 64;
  localparam int unsigned PtrW = 6;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    EMIT     = 2'd1,
    EMIT_PAD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [BlkW-1:0]   blk_q, blk_d;
  logic [PtrW-1:0]   p_q, p_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pad_q, pad_d;
  logic              marker_q, marker_d;
  logic              armed_q, armed_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [LenW-1:0]   len_c;

  assign byte_ready  = ready_q;
  assign block_valid = valid_q;
  assign block_data  = blk_q;
  assign block_first = first_q;
  assign block_last  = last_q;
  assign busy        = busy_q;

  // State register and datapath registers; reset drops any partial block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= FILL;
      blk_q    <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      pad_q    <= 1'b0;
      marker_q <= 1'b0;
      armed_q  <= 1'b1;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      pad_q    <= pad_d;
      marker_q <= marker_d;
      armed_q  <= armed_d;
      first_q  <= first_d;
      last_q   <= last_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state: byte capture, in-place padding, block hand-off.
  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    pad_d    = pad_q;
    marker_d = marker_q;
    armed_d  = armed_q;
    first_d  = first_q;
    last_d   = last_q;
    len_c    = {cnt_q, 3'b000};

    unique case (state_q)
      FILL: begin
        if (byte_valid && ready_q) begin
          for (int k = 0; k < 64; k++) begin
            if (PtrW'(k) == p_q) blk_d[8*(63-k) +: 8] = byte_data;
          end
          cnt_d = cnt_q + CntW'(1);
          p_d   = p_q + PtrW'(1);
          if (byte_last) begin
            len_c = {cnt_d, 3'b000};
            for (int k = 0; k < 64; k++) begin
              if (k == int'(p_q) + 1) blk_d[8*(63-k) +: 8] = 8'h80;
              else if (k > int'(p_q) + 1) blk_d[8*(63-k) +: 8] = 8'h00;
            end
            if (p_q <= PtrW'(54)) begin
              blk_d[LenW-1:0] = len_c;
              last_d   = 1'b1;
              pad_d    = 1'b0;
              marker_d = 1'b0;
            end else begin
              last_d   = 1'b0;
              pad_d    = 1'b1;
              marker_d = (p_q == PtrW'(63));
            end
            p_d     = '0;
            first_d = armed_q;
            state_d = EMIT;
          end else if (p_q == PtrW'(63)) begin
            first_d = armed_q;
            last_d  = 1'b0;
            pad_d   = 1'b0;
            state_d = EMIT;
          end
        end else if (empty_msg && ready_q && !byte_valid &&
                     (p_q == '0) && (cnt_q == '0)) begin
          blk_d    = {8'h80, 504'b0};
          first_d  = armed_q;
          last_d   = 1'b1;
          pad_d    = 1'b0;
          marker_d = 1'b0;
          state_d  = EMIT;
        end
      end

      EMIT: begin
        if (block_ready) begin
          armed_d = 1'b0;
          first_d = 1'b0;
          if (pad_q) begin
            blk_d           = '0;
            blk_d[511:504]  = marker_q ? 8'h80 : 8'h00;
            blk_d[LenW-1:0] = len_c;
            last_d          = 1'b1;
            pad_d           = 1'b0;
            marker_d        = 1'b0;
            state_d         = EMIT_PAD;
          end else begin
            if (last_q) begin
              cnt_d   = '0;
              armed_d = 1'b1;
            end
            last_d  = 1'b0;
            state_d = FILL;
          end
        end
      end

      EMIT_PAD: begin
        if (block_ready) begin
          cnt_d   = '0;
          armed_d = 1'b1;
          first_d = 1'b0;
          last_d  = 1'b0;
          state_d = FILL;
        end
      end

      default: state_d = FILL;
    endcase

    ready_d = (state_d == FILL);
    valid_d = (state_d != FILL);
    busy_d  = (state_d != FILL) || (p_d != '0) || (cnt_d != '0);
  end

endmodule
